// File: rtl/pwm_ramp_pkg.sv
// Shared types and constants for the PWM setpoint ramp controller.
package pwm_ramp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STEP
    } ramp_state_t;

    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/tick_edge_sync.sv
// Brings the modulator's period strobe into the clk domain and emits one pulse per rising edge.
module tick_edge_sync
    import pwm_ramp_pkg::*;
(
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // A strobe held high for many cycles still yields a single pulse.
    assign rise = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/pwm_ramp_controller.sv
// Ramps pwm_modulator's setpoint toward a commanded target, one bounded step every N PWM periods.
module pwm_ramp_controller
    import pwm_ramp_pkg::*;
#(
    parameter int unsigned          MOD_WIDTH     = 8,
    parameter int unsigned          STEP_WIDTH    = 8,
    parameter int unsigned          HOLD_WIDTH    = 8,
    parameter logic [MOD_WIDTH-1:0] INIT_SETPOINT = '0
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [MOD_WIDTH-1:0]  cmd_target,
    input  logic [STEP_WIDTH-1:0] cmd_step,
    input  logic [HOLD_WIDTH-1:0] cmd_hold,
    input  logic                  abort,
    input  logic                  period_tick,
    output logic [MOD_WIDTH-1:0]  mod_setpoint,
    output logic                  ramp_busy,
    output logic                  ramp_done
);

    // Wide enough for an unwrapped |target - setpoint| and for the full step value.
    localparam int unsigned CW = (MOD_WIDTH + 1 > STEP_WIDTH) ? MOD_WIDTH + 1 : STEP_WIDTH;

    ramp_state_t           state_q, state_d;
    logic [MOD_WIDTH-1:0]  setpoint_q, setpoint_d;
    logic [MOD_WIDTH-1:0]  target_q, target_d;
    logic [STEP_WIDTH-1:0] step_q, step_d;
    logic [HOLD_WIDTH-1:0] hold_q, hold_d;
    logic [HOLD_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
    logic                  done_q, done_d;

    logic                  tick_evt;
    logic [STEP_WIDTH-1:0] cmd_step_eff;
    logic [HOLD_WIDTH-1:0] cmd_hold_eff;
    logic [CW-1:0]         sp_ext, tgt_ext, step_ext, diff;
    logic                  going_up;

    tick_edge_sync u_tick_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    (period_tick),
        .rise (tick_evt)
    );

    assign cmd_step_eff = (cmd_step == '0) ? STEP_WIDTH'(1) : cmd_step;
    assign cmd_hold_eff = (cmd_hold == '0) ? HOLD_WIDTH'(1) : cmd_hold;

    always_comb begin
        sp_ext   = CW'(setpoint_q);
        tgt_ext  = CW'(target_q);
        step_ext = CW'(step_q);
        going_up = (tgt_ext >= sp_ext);
        diff     = going_up ? (tgt_ext - sp_ext) : (sp_ext - tgt_ext);
    end

    always_comb begin
        state_d    = state_q;
        setpoint_d = setpoint_q;
        target_d   = target_q;
        step_d     = step_q;
        hold_d     = hold_q;
        hold_cnt_d = hold_cnt_q;
        done_d     = 1'b0;

        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        target_d   = cmd_target;
                        step_d     = cmd_step_eff;
                        hold_d     = cmd_hold_eff;
                        hold_cnt_d = cmd_hold_eff;
                        if (cmd_target == setpoint_q) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (tick_evt) begin
                        hold_cnt_d = hold_cnt_q - HOLD_WIDTH'(1);
                        if (hold_cnt_q == HOLD_WIDTH'(1)) begin
                            state_d = STEP;
                        end
                    end
                end
                STEP: begin
                    // Final step clamps onto the target so extremes never wrap.
                    if (diff <= step_ext) begin
                        setpoint_d = target_q;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        setpoint_d = going_up ? (setpoint_q + step_ext[MOD_WIDTH-1:0])
                                              : (setpoint_q - step_ext[MOD_WIDTH-1:0]);
                        hold_cnt_d = hold_q;
                        state_d    = WAIT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            setpoint_q <= INIT_SETPOINT;
            target_q   <= INIT_SETPOINT;
            step_q     <= STEP_WIDTH'(1);
            hold_q     <= HOLD_WIDTH'(1);
            hold_cnt_q <= HOLD_WIDTH'(1);
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            setpoint_q <= setpoint_d;
            target_q   <= target_d;
            step_q     <= step_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
            done_q     <= done_d;
        end
    end

    assign cmd_ready    = (state_q == IDLE);
    assign ramp_busy    = (state_q != IDLE);
    assign ramp_done    = done_q;
    assign mod_setpoint = setpoint_q;

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Directed bench for pwm_ramp_controller with hand-computed setpoint sequences.
module tb_pwm_ramp_controller;

    logic       clk;
    logic       nrst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_target;
    logic [7:0] cmd_step;
    logic [7:0] cmd_hold;
    logic       abort;
    logic       period_tick;
    logic [7:0] mod_setpoint;
    logic       ramp_busy;
    logic       ramp_done;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int done_val = -1;

    pwm_ramp_controller #(
        .MOD_WIDTH     (8),
        .STEP_WIDTH    (8),
        .HOLD_WIDTH    (8),
        .INIT_SETPOINT (8'd0)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_target   (cmd_target),
        .cmd_step     (cmd_step),
        .cmd_hold     (cmd_hold),
        .abort        (abort),
        .period_tick  (period_tick),
        .mod_setpoint (mod_setpoint),
        .ramp_busy    (ramp_busy),
        .ramp_done    (ramp_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ramp_done) begin
            done_cnt = done_cnt + 1;
            done_val = int'(mod_setpoint);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks = n_checks + 1;
        if (got == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Short strobe, then enough settle time for the step to land.
    task automatic tick();
        period_tick = 1'b1;
        cycles(2);
        period_tick = 1'b0;
        cycles(6);
    endtask

    task automatic send(input int tgt, input int stp, input int hld);
        int waited = 0;
        while (!cmd_ready && waited < 100) begin
            cycles(1);
            waited++;
        end
        check("cmd_ready before send", int'(cmd_ready), 1);
        cmd_target = 8'(tgt);
        cmd_step   = 8'(stp);
        cmd_hold   = 8'(hld);
        cmd_valid  = 1'b1;
        cycles(1);
        cmd_valid  = 1'b0;
    endtask

    int exp_up [8] = '{0, 3, 3, 6, 6, 9, 9, 10};
    int d0;

    initial begin
        nrst = 1'b0; cmd_valid = 1'b0; cmd_target = '0; cmd_step = '0; cmd_hold = '0;
        abort = 1'b0; period_tick = 1'b0;
        cycles(3);
        check("reset setpoint", int'(mod_setpoint), 0);
        check("reset cmd_ready", int'(cmd_ready), 1);
        check("reset ramp_busy", int'(ramp_busy), 0);
        check("reset ramp_done", int'(ramp_done), 0);
        nrst = 1'b1;
        cycles(2);

        // 1: ticks without a command do nothing
        for (int i = 0; i < 20; i++) tick();
        check("idle ticks setpoint", int'(mod_setpoint), 0);
        check("idle ticks no done", done_cnt, 0);

        // 2: up-ramp 0 -> 10, step 3, hold 2
        send(10, 3, 2);
        check("up busy", int'(ramp_busy), 1);
        check("up not ready", int'(cmd_ready), 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("up tick %0d", i + 1), int'(mod_setpoint), exp_up[i]);
            if (i < 7) check($sformatf("up ready %0d", i + 1), int'(cmd_ready), 0);
        end
        check("up done count", done_cnt, 1);
        check("up done value", done_val, 10);
        check("up ready after", int'(cmd_ready), 1);
        check("up busy after", int'(ramp_busy), 0);

        // 3: reach 250, then ramp down to 0 with clamp
        send(250, 255, 1);
        tick();
        check("to 250", int'(mod_setpoint), 250);
        d0 = done_cnt;
        send(0, 100, 1);
        // exact latency: setpoint changes on the 4th edge after the strobe rises
        period_tick = 1'b1;
        cycles(3);
        check("latency edge3 unchanged", int'(mod_setpoint), 250);
        cycles(1);
        check("latency edge4 updated", int'(mod_setpoint), 150);
        period_tick = 1'b0;
        cycles(4);
        tick();
        check("down 50", int'(mod_setpoint), 50);
        tick();
        check("down 0 no wrap", int'(mod_setpoint), 0);
        check("down done once", done_cnt - d0, 1);
        tick();
        check("down stays 0", int'(mod_setpoint), 0);

        // 4: step=0/hold=0 treated as 1/1; equal target completes immediately
        send(5, 10, 1);
        tick();
        check("to 5", int'(mod_setpoint), 5);
        send(7, 0, 0);
        tick();
        check("zero step tick1", int'(mod_setpoint), 6);
        tick();
        check("zero step tick2", int'(mod_setpoint), 7);
        d0 = done_cnt;
        send(7, 4, 4);
        check("equal target done", int'(ramp_done), 1);
        check("equal target not busy", int'(ramp_busy), 0);
        cycles(1);
        check("equal target done one pulse", done_cnt - d0, 1);
        check("equal target done low", int'(ramp_done), 0);

        // 5: abort freezes the ramp
        send(0, 255, 1);
        tick();
        check("to 0", int'(mod_setpoint), 0);
        send(200, 10, 1);
        tick(); tick(); tick();
        check("abort pre value", int'(mod_setpoint), 30);
        d0 = done_cnt;
        abort = 1'b1;
        cycles(1);
        abort = 1'b0;
        check("abort busy", int'(ramp_busy), 0);
        check("abort ready", int'(cmd_ready), 1);
        tick(); tick();
        check("abort frozen", int'(mod_setpoint), 30);
        check("abort no done", done_cnt - d0, 0);

        // abort coincident with the STEP cycle
        send(60, 10, 1);
        period_tick = 1'b1;
        cycles(3);
        abort = 1'b1;
        period_tick = 1'b0;
        cycles(1);
        abort = 1'b0;
        check("abort step no update", int'(mod_setpoint), 30);
        check("abort step idle", int'(ramp_busy), 0);
        tick();
        check("abort step frozen", int'(mod_setpoint), 30);
        check("abort step no done", done_cnt - d0, 0);

        // abort with cmd_valid in IDLE drops the command
        cmd_target = 8'd99; cmd_step = 8'd50; cmd_hold = 8'd1;
        cmd_valid = 1'b1; abort = 1'b1;
        cycles(1);
        cmd_valid = 1'b0; abort = 1'b0;
        check("abort drops cmd busy", int'(ramp_busy), 0);
        tick();
        check("abort drops cmd value", int'(mod_setpoint), 30);

        send(40, 10, 1);
        tick();
        check("resume 40", int'(mod_setpoint), 40);
        check("resume done", done_cnt - d0, 1);

        // 6: a long-held strobe counts once
        send(50, 10, 2);
        period_tick = 1'b1;
        cycles(50);
        period_tick = 1'b0;
        cycles(6);
        check("long tick one decrement", int'(mod_setpoint), 40);
        check("long tick still busy", int'(ramp_busy), 1);
        tick();
        check("long tick then step", int'(mod_setpoint), 50);

        // async reset mid-WAIT
        send(100, 10, 5);
        tick();
        #2;
        nrst = 1'b0;
        #1;
        check("async rst setpoint", int'(mod_setpoint), 0);
        check("async rst ready", int'(cmd_ready), 1);
        check("async rst busy", int'(ramp_busy), 0);
        check("async rst done", int'(ramp_done), 0);
        cycles(2);
        nrst = 1'b1;
        tick(); tick();
        check("after rst no ramp", int'(mod_setpoint), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
